// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned INDEX_BITS_DEF   = 6;
    localparam int unsigned OFFSET_WORDS_DEF = 2;

    // kseg1 window: 0xA000_0000 - 0xBFFF_FFFF, fetched uncached
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] KSEG1_MASK = 32'hE000_0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2,
        ST_UNCACHED  = 2'd3
    } state_e;

    // Lowest address bit above the byte-in-line offset
    function automatic int unsigned line_lsb(input int unsigned offset_words);
        return offset_words + 2;
    endfunction

    // Lowest address bit of the tag field
    function automatic int unsigned tag_lsb(input int unsigned index_bits,
                                            input int unsigned offset_words);
        return index_bits + offset_words + 2;
    endfunction

    function automatic logic is_kseg1(input logic [31:0] addr);
        return (addr & KSEG1_MASK) == KSEG1_BASE;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss/uncached sequencer: state, beat counter, memory handshake, deferred invalidate.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int unsigned OFFSET_WORDS = OFFSET_WORDS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_fill,
    input  logic                    start_uc,
    input  logic [31:0]             cpu_pc,
    input  logic                    inv_all,
    input  logic                    mem_ack,
    output state_e                  state,
    output logic [OFFSET_WORDS-1:0] beat,
    output logic                    pend_inv,
    output logic                    byp_out,
    output logic [31:0]             line_addr,
    output logic                    mem_req,
    output logic [31:0]             mem_addr
);

    localparam int unsigned LINE_LSB = line_lsb(OFFSET_WORDS);
    localparam logic [31:0] LINE_MASK = 32'((64'd1 << LINE_LSB) - 64'd1);
    localparam logic [OFFSET_WORDS-1:0] BEAT_LAST = '1;

    state_e                  state_q, state_d;
    logic [OFFSET_WORDS-1:0] beat_q, beat_d;
    logic                    pend_inv_q, pend_inv_d;
    logic                    byp_q, byp_d;
    logic [31:0]             line_q, line_d;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;

    // Next-state and next-output logic; memory request signals are registered
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pend_inv_d = pend_inv_q;
        byp_d      = byp_q;
        line_d     = line_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_uc) begin
                    state_d    = ST_UNCACHED;
                    byp_d      = 1'b0;
                    pend_inv_d = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = cpu_pc & ~32'h3;
                end else if (start_fill) begin
                    state_d    = ST_REFILL;
                    beat_d     = '0;
                    pend_inv_d = 1'b0;
                    line_d     = cpu_pc & ~LINE_MASK;
                    mem_req_d  = 1'b1;
                    mem_addr_d = cpu_pc & ~LINE_MASK;
                end
            end
            ST_REFILL: begin
                if (inv_all) begin
                    pend_inv_d = 1'b1;
                end
                if (mem_ack) begin
                    beat_d = beat_q + OFFSET_WORDS'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d   = ST_FILL_DONE;
                        mem_req_d = 1'b0;
                    end else begin
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            ST_FILL_DONE: begin
                pend_inv_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_UNCACHED: begin
                if (byp_q) begin
                    // bypass word presented this cycle; nothing left in flight
                    byp_d      = 1'b0;
                    pend_inv_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    if (inv_all) begin
                        pend_inv_d = 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        byp_d     = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and handshake registers; reset aborts any refill in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            pend_inv_q <= 1'b0;
            byp_q      <= 1'b0;
            line_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pend_inv_q <= pend_inv_d;
            byp_q      <= byp_d;
            line_q     <= line_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign state     = state_q;
    assign beat      = beat_q;
    assign pend_inv  = pend_inv_q;
    assign byp_out   = byp_q;
    assign line_addr = line_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: flop arrays, same-cycle hit path, counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS   = INDEX_BITS_DEF,
    parameter int unsigned OFFSET_WORDS = OFFSET_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    input  logic        inv_all,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned WORDS    = 1 << OFFSET_WORDS;
    localparam int unsigned LINE_LSB = line_lsb(OFFSET_WORDS);
    localparam int unsigned TAG_LSB  = tag_lsb(INDEX_BITS, OFFSET_WORDS);
    localparam int unsigned TAG_BITS = 32 - TAG_LSB;

    state_e                  state;
    logic [OFFSET_WORDS-1:0] beat;
    logic                    pend_inv;
    logic                    byp_out;
    logic [31:0]             line_addr;

    logic [31:0]         data_mem [LINES][WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q, valid_d;
    logic [31:0]         byp_data_q, byp_data_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [TAG_BITS-1:0]     tag_c, fill_tag_c;
    logic [INDEX_BITS-1:0]   idx_c, fill_idx_c;
    logic [OFFSET_WORDS-1:0] word_c;
    logic [LINE_LSB-1:0]     unused_line_lsbs;
    logic idle_c, uc_c, lookup_hit_c, hit_ev_c, start_fill_c, start_uc_c, fill_we_c;

    assign tag_c            = cpu_pc[31:TAG_LSB];
    assign idx_c            = cpu_pc[TAG_LSB-1:LINE_LSB];
    assign word_c           = cpu_pc[LINE_LSB-1:2];
    assign fill_tag_c       = line_addr[31:TAG_LSB];
    assign fill_idx_c       = line_addr[TAG_LSB-1:LINE_LSB];
    assign unused_line_lsbs = line_addr[LINE_LSB-1:0];

    // Lookup classification for the current fetch
    always_comb begin
        idle_c       = (state == ST_IDLE);
        uc_c         = is_kseg1(cpu_pc);
        lookup_hit_c = valid_q[idx_c] && (tag_mem[idx_c] == tag_c);
        hit_ev_c     = idle_c && cpu_req && !uc_c && lookup_hit_c;
        start_fill_c = idle_c && cpu_req && !uc_c && !lookup_hit_c;
        start_uc_c   = idle_c && cpu_req && uc_c;
        fill_we_c    = (state == ST_REFILL) && mem_ack;
    end

    icache_refill_fsm #(
        .OFFSET_WORDS (OFFSET_WORDS)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst),
        .start_fill (start_fill_c),
        .start_uc   (start_uc_c),
        .cpu_pc     (cpu_pc),
        .inv_all    (inv_all),
        .mem_ack    (mem_ack),
        .state      (state),
        .beat       (beat),
        .pend_inv   (pend_inv),
        .byp_out    (byp_out),
        .line_addr  (line_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr)
    );

    // Valid bits: drop the victim on miss, flash-clear on invalidate, set after fill
    always_comb begin
        valid_d = valid_q;
        if (start_fill_c) begin
            valid_d[idx_c] = 1'b0;
        end
        if (inv_all) begin
            valid_d = '0;
        end
        if (state == ST_FILL_DONE) begin
            valid_d[fill_idx_c] = !pend_inv && !inv_all;
        end
    end

    // Bypass word capture and event counters
    always_comb begin
        byp_data_d = byp_data_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state == ST_UNCACHED) && !byp_out && mem_ack) begin
            byp_data_d = mem_rdata;
        end
        if (hit_ev_c) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (start_fill_c) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Resettable control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            byp_data_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            byp_data_q <= byp_data_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Data and tag arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            data_mem[fill_idx_c][beat] <= mem_rdata;
        end
        if (state == ST_FILL_DONE) begin
            tag_mem[fill_idx_c] <= fill_tag_c;
        end
    end

    // Fetch response: same-cycle hit data, bypass word, or stall
    always_comb begin
        cpu_instr = '0;
        cpu_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (uc_c || !lookup_hit_c) begin
                        cpu_stall = 1'b1;
                    end else begin
                        cpu_instr = data_mem[idx_c][word_c];
                    end
                end
            end
            ST_REFILL, ST_FILL_DONE: cpu_stall = 1'b1;
            ST_UNCACHED: begin
                if (byp_out) begin
                    cpu_instr = byp_data_q;
                end else begin
                    cpu_stall = 1'b1;
                end
            end
            default: cpu_stall = 1'b0;
        endcase
        // reset releases the core immediately
        if (!rst) begin
            cpu_instr = '0;
            cpu_stall = 1'b0;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the core's fetch port (pcF/instrF) and an external word-wide memory port with a req/ack handshake.
- Hits return the instruction in the same cycle as the lookup.
- Misses assert a stall that the hazard unit ORs into stallF and stallD, refill a full line with sequential word beats, and then release the stall.
- kseg1 addresses (0xA000_0000–0xBFFF_FFFF) bypass the cache as single-word uncached fetches.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines)
OFFSET_WORDS, 2, log2 of words per line (4 words = 16 B)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
cpu_req  in  1  fetch valid; pcF is meaningful this cycle
cpu_pc  in  32  fetch address, word aligned (bits[1:0] ignored)
cpu_instr  out  32  instruction; valid when cpu_req && !cpu_stall
cpu_stall  out  1  fetch not yet satisfied; core holds PC and IF/ID
inv_all  in  1  one-cycle pulse: invalidate every line
mem_req  out  1  word read request; held until mem_ack
mem_addr  out  32  word address of the request; stable while mem_req
mem_ack  in  1  beat complete; mem_rdata valid this cycle
mem_rdata  in  32  returned word
hit_cnt  out  32  cached hits, wraps
miss_cnt  out  32  line refills started, wraps

Behaviour:
- Address split: tag = pc[31:INDEX_BITS+OFFSET_WORDS+2], index = next INDEX_BITS bits, word = pc[OFFSET_WORDS+1:2].
- Storage: data, tag and valid arrays are flip-flops with combinational read and a synchronous write.
- Reset (rst=0): state IDLE, all valid bits 0, mem_req=0, mem_addr=0, cpu_instr=0, cpu_stall=0, beat counter 0, counters 0, pend_inv=0.
- Reset mid-refill aborts the refill immediately; the partial line is never validated.
- FSM states: IDLE, REFILL, FILL_DONE, UNCACHED.
- IDLE:
  - No cpu_req: cpu_stall=0.
  - Cached hit (valid && tag match): cpu_instr=data[index][word], cpu_stall=0, hit_cnt++.
  - Cached miss: cpu_stall=1 combinationally; latch line base address; go to REFILL; miss_cnt++.
  - kseg1 address: cpu_stall=1; go to UNCACHED.
- REFILL:
  - mem_req=1, mem_addr = line base + 4*beat.
  - On mem_ack: write mem_rdata into data[index][beat] and beat++.
  - The beat where beat == 2^OFFSET_WORDS − 1 goes to FILL_DONE.
  - cpu_stall=1 throughout.
- FILL_DONE:
  - Write tag and set valid = !pend_inv; clear pend_inv; cpu_stall=1; return to IDLE.
  - The next IDLE lookup hits, unless the line was invalidated.
  - Miss penalty = N acked beats + 2 cycles (FILL_DONE + IDLE lookup).
- UNCACHED:
  - mem_req=1, mem_addr={pc[31:2],2'b00}.
  - On mem_ack: capture mem_rdata into a bypass register and drive cpu_instr from it with cpu_stall=0 for exactly one cycle (state BYP_OUT folded into UNCACHED via a flag), then return to IDLE.
  - No array write; neither counter changes.
- mem_req deasserts in the cycle after the final ack. It is never asserted in IDLE or FILL_DONE.
- inv_all:
  - In IDLE: all valid bits clear at the next edge. A lookup in the same cycle uses the old contents.
  - In REFILL or UNCACHED: all valid bits clear and pend_inv=1, so the in-flight line is not validated.
- cpu_pc changing while cpu_stall=1 is illegal (the core holds the PC). A bench assertion flags it.
- Counter overflow wraps to 0.

Decomposition:
- Shared package icache_pkg: state enum, KSEG1_BASE/KSEG1_MASK constants, field-width localparam derivations.
- Natural sub-module: icache_refill_fsm (state register, beat counter, mem_* handshake, pend_inv). The top keeps the arrays, hit logic and counters.

Test Plan:
- Cold fetch pc=0xBFC0_0000 (kseg1), memory returns 0x3C08_BFC0 after 3 cycles → one mem_req at 0xBFC0_0000, cpu_instr=0x3C08_BFC0 with stall low for 1 cycle, miss_cnt=0.
- Fetch pc=0x0000_0040 cold, ack every cycle → beats at 0x40, 0x44, 0x48, 0x4C. Stall high for 6 cycles (4 beats + FILL_DONE + 1 cycle latency-to-lookup edge), then cpu_instr = word 0; miss_cnt=1. Sequential fetch of 0x44..0x4C hits with no stall; hit_cnt=4.
- Conflict: pc=0x0000_0040, then pc=0x0000_0440 (same index, different tag), then 0x40 again → three refills, miss_cnt=3.
- inv_all pulsed during beat 2 of the 0x40 refill → refill completes, next lookup of 0x40 misses again; miss_cnt increments twice total.
- rst driven low during beat 1 of a refill → mem_req=0 asynchronously, cpu_stall=0. After release, fetch of 0x40 misses (valid cleared).
- mem_ack withheld 20 cycles → mem_req and mem_addr stay stable and cpu_stall stays 1 throughout.
